// File: rtl/char_draw_controller_pkg.sv
// char_draw_controller_pkg: shared sprite geometry, lane limits, FSM encoding and colours
package char_draw_controller_pkg;

    localparam int SPRITE_W   = 9;
    localparam int SPRITE_H   = 5;
    localparam int LANE_COUNT = 9;

    localparam logic [3:0] DEFAULT_LANE = 4'd4;
    localparam logic [3:0] MAX_LANE     = 4'(LANE_COUNT - 1);
    localparam logic [3:0] LAST_COL     = 4'(SPRITE_W - 1);
    localparam logic [2:0] LAST_ROW     = 3'(SPRITE_H - 1);

    localparam logic [2:0] COLOUR_BLACK = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERASE,
        S_DRAW,
        S_FINISH
    } state_t;

endpackage

// File: rtl/char_draw_controller_sprite_pixel_counter.sv
// sprite_pixel_counter: column-inner / row-outer scan over the sprite; holds the pixel to emit at the next edge
module sprite_pixel_counter
    import char_draw_controller_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       start,
    input  logic       advance,
    output logic [3:0] column,
    output logic [2:0] row,
    output logic       last
);

    logic       col_wrap;
    logic [3:0] next_column;
    logic [2:0] next_row;

    // next scan position; the last pixel wraps back to (0,0)
    always_comb begin
        col_wrap    = column == LAST_COL;
        last        = col_wrap && row == LAST_ROW;
        next_column = col_wrap ? 4'd0 : column + 4'd1;
        next_row    = last ? 3'd0 : (col_wrap ? row + 3'd1 : row);
    end

    // position register, cleared by reset or start, stepped by advance
    always_ff @(posedge Clock) begin
        if (!Reset || start) begin
            column <= 4'd0;
            row    <= 3'd0;
        end else if (advance) begin
            column <= next_column;
            row    <= next_row;
        end
    end

endmodule

// File: rtl/char_draw_controller.sv
// char_draw_controller: erases the sprite at the old lane and redraws it at the requested lane, one pixel per cycle
module char_draw_controller
    import char_draw_controller_pkg::*;
#(
    parameter logic [7:0] LANE_BASE_X = 8'd6,
    parameter logic [7:0] LANE_PITCH  = 8'd18,
    parameter logic [6:0] BASE_Y      = 7'd7,
    parameter logic [2:0] BG_COLOUR   = COLOUR_BLACK
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] CurrState,
    input  logic [2:0] Colour,
    output logic [7:0] XOut,
    output logic [6:0] YOut,
    output logic [2:0] ColourOut,
    output logic       Plot,
    output logic       Busy,
    output logic       Done
);

    state_t     state;
    logic [3:0] saved_lane;
    logic [3:0] new_lane;
    logic       init_pending;
    logic       final_px;
    logic [3:0] column;
    logic [2:0] row;
    logic       last;
    logic       go_init;
    logic       go_move;
    logic       cnt_adv;
    logic       cnt_start;
    logic [3:0] px_lane;
    logic [7:0] px_x;
    logic [6:0] px_y;

    function automatic logic [7:0] pix_x(input logic [3:0] lane, input logic [3:0] col);
        return LANE_BASE_X + LANE_PITCH * {4'd0, lane} + {4'd0, col};
    endfunction

    function automatic logic [6:0] pix_y(input logic [2:0] r);
        return BASE_Y - {4'd0, r};
    endfunction

    sprite_pixel_counter u_counter (
        .Clock   (Clock),
        .Reset   (Reset),
        .start   (cnt_start),
        .advance (cnt_adv),
        .column  (column),
        .row     (row),
        .last    (last)
    );

    // move requests, counter control and the pixel that the next edge will present
    always_comb begin
        go_init   = state == S_IDLE && init_pending;
        go_move   = state == S_IDLE && !init_pending && CurrState <= MAX_LANE && CurrState != saved_lane;
        cnt_adv   = go_init || go_move || state == S_ERASE || (state == S_DRAW && !final_px);
        cnt_start = state == S_FINISH;
        px_lane   = (state == S_IDLE || (state == S_ERASE && !final_px)) ? saved_lane : new_lane;
        px_x      = pix_x(px_lane, column);
        px_y      = pix_y(row);
    end

    // move sequencer with registered pixel, status and handshake outputs
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state        <= S_IDLE;
            saved_lane   <= DEFAULT_LANE;
            new_lane     <= DEFAULT_LANE;
            init_pending <= 1'b1;
            final_px     <= 1'b0;
            XOut         <= 8'd0;
            YOut         <= 7'd0;
            ColourOut    <= 3'd0;
            Plot         <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
        end else begin
            final_px <= cnt_adv && last;
            case (state)
                S_IDLE: begin
                    Done <= 1'b0;
                    if (go_init || go_move) begin
                        state     <= go_init ? S_DRAW : S_ERASE;
                        new_lane  <= go_init ? saved_lane : CurrState;
                        ColourOut <= go_init ? Colour : BG_COLOUR;
                        XOut      <= px_x;
                        YOut      <= px_y;
                        Plot      <= 1'b1;
                        Busy      <= 1'b1;
                    end
                end
                S_ERASE: begin
                    XOut <= px_x;
                    YOut <= px_y;
                    if (final_px) begin
                        state     <= S_DRAW;
                        ColourOut <= Colour;
                    end
                end
                S_DRAW: begin
                    if (final_px) begin
                        state <= S_FINISH;
                        Plot  <= 1'b0;
                        Done  <= 1'b1;
                    end else begin
                        XOut <= px_x;
                        YOut <= px_y;
                    end
                end
                S_FINISH: begin
                    state        <= S_IDLE;
                    Done         <= 1'b0;
                    Busy         <= 1'b0;
                    saved_lane   <= new_lane;
                    init_pending <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_draw_controller.sv
// tb_char_draw_controller: scoreboard bench; the model lists every expected pixel and Done pulse with its cycle
module tb_char_draw_controller;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [3:0] CurrState = 4'd4;
    logic [2:0] Colour = 3'b100;
    logic [7:0] XOut;
    logic [6:0] YOut;
    logic [2:0] ColourOut;
    logic       Plot;
    logic       Busy;
    logic       Done;

    char_draw_controller dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .CurrState (CurrState),
        .Colour    (Colour),
        .XOut      (XOut),
        .YOut      (YOut),
        .ColourOut (ColourOut),
        .Plot      (Plot),
        .Busy      (Busy),
        .Done      (Done)
    );

    initial forever #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        bit done;
        int x;
        int y;
        int c;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  m_saved = 4;
    int  t_ready = 0;
    int  last_start = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(negedge Clock);
        #1;
    endtask

    task automatic push_pass(input int lane, input int colour, input int first);
        for (int i = 0; i < 45; i++)
            exp_q.push_back('{1'b0, 6 + 18 * lane + i % 9, 7 - i / 9, colour, first + i});
    endtask

    // command visible at edge k+1: pixels from cycle k+1, Done right after the last draw pixel
    task automatic push_move(input int from, input int to, input int colour, input int k, input bit erase);
        int t;
        t = k + 1;
        if (erase) begin
            push_pass(from, 0, t);
            t += 45;
        end
        push_pass(to, colour, t);
        t += 45;
        exp_q.push_back('{1'b1, 6 + 18 * to + 8, 3, colour, t});
    endtask

    task automatic command(input logic [3:0] lane, input logic [2:0] col);
        int k;
        CurrState = lane;
        Colour = col;
        if (lane <= 4'd8 && int'(lane) != m_saved) begin
            k = (cyc > t_ready) ? cyc : t_ready;
            push_move(m_saved, int'(lane), int'(col), k, 1'b1);
            last_start = k;
            m_saved = int'(lane);
            t_ready = k + 92;
        end
    endtask

    task automatic release_reset;
        Reset = 1'b1;
        push_move(4, 4, int'(Colour), cyc, 1'b0);
        m_saved = 4;
        t_ready = cyc + 47;
    endtask

    task automatic wait_ready;
        while (cyc < t_ready) tick;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_x"}, 32'(XOut), 0);
        chk({tag, "_y"}, 32'(YOut), 0);
        chk({tag, "_colour"}, 32'(ColourOut), 0);
        chk({tag, "_plot"}, 32'(Plot), 0);
        chk({tag, "_busy"}, 32'(Busy), 0);
        chk({tag, "_done"}, 32'(Done), 0);
    endtask

    ev_t         e;
    logic [20:0] exp_v;

    // monitor: every plotted pixel or Done pulse must match the head of the scoreboard
    always @(negedge Clock) begin
        if (Plot || Done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: plot=%0b done=%0b x=%0d y=%0d at cycle %0d", Plot, Done, XOut, YOut, cyc);
            end else begin
                e = exp_q.pop_front();
                exp_v = {!e.done, e.done, 1'b1, 8'(e.x), 7'(e.y), 3'(e.c)};
                chk(e.done ? "done_event" : "pixel", 32'({Plot, Done, Busy, XOut, YOut, ColourOut}), 32'(exp_v));
                chk("event_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        int b;
        repeat (3) tick;
        check_reset("reset");
        release_reset;
        wait_ready;
        command(4'd3, 3'b010);
        wait_ready;
        command(4'd7, 3'b001);
        wait_ready;
        command(4'd8, 3'b111);
        wait_ready;
        command(4'd12, 3'b101);
        repeat (100) begin
            tick;
            chk("invalid_busy", 32'(Busy), 0);
            chk("invalid_plot", 32'(Plot), 0);
        end
        command(4'd4, 3'b011);
        wait_ready;
        command(4'd5, 3'b110);
        while (cyc < last_start + 21) tick;
        command(4'd6, 3'b110);
        wait_ready;
        command(4'd2, 3'b001);
        while (cyc < last_start + 76) tick;
        Reset = 1'b0;
        CurrState = 4'd4;
        Colour = 3'b101;
        exp_q.delete();
        tick;
        chk("abort_plot", 32'(Plot), 0);
        chk("abort_busy", 32'(Busy), 0);
        chk("abort_done", 32'(Done), 0);
        tick;
        check_reset("reset2");
        release_reset;
        wait_ready;
        repeat (25) begin
            repeat ($urandom_range(0, 4)) tick;
            command(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            tick;
            wait_ready;
        end
        b = 0;
        while (exp_q.size() != 0 && b < 500) begin
            tick;
            b++;
        end
        chk("drain", 32'(exp_q.size()), 0);
        repeat (3) tick;
        chk("final_busy", 32'(Busy), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
